// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage on the reader side of the instruction memory. The unit holds
// the program counter and drives it as the word address. It captures the
// word that the memory returns combinationally for that address, and it
// presents the word to decode through a valid/ready handshake. It also
// handles program selection at start, redirects from execute, stalls, and
// the halt at the end of the program.
//
// Ports:
//   clock          in   1   sole clock, rising edge
//   reset          in   1   asynchronous, active-high
//   start          in   1   one-cycle pulse, loads PC from the prog_sel base
//   prog_sel       in   2   program select, sampled with start
//   address        out 10   word address to instruction memory (PC register)
//   instrucao      in  32   memory word for the current address
//   redirect       in   1   execute-stage PC override
//   redirect_addr  in  10   new PC when redirect=1
//   instr_out      out 32   registered instruction to decode
//   pc_out         out 10   address instr_out was fetched from
//   instr_valid    out  1   instr_out/pc_out hold a valid instruction
//   instr_ready    in   1   decode accepts this cycle
//   halted         out  1   program finished, no further fetches
//
// Build option:
//   FETCH_JUMP_PREDECODE_EN  When this macro is defined, a captured word with
//                            opcode 6'b010000 is a jump. Fetch loads its low
//                            10 bits into PC instead of PC+1. The word still
//                            goes to decode, which treats it as a no-op.
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter int unsigned PC_LIMIT = 80,
    parameter int unsigned BASE_P0  = 1,
    parameter int unsigned BASE_P1  = 25,
    parameter int unsigned BASE_P2  = 35
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  prog_sel,
    output logic [9:0]  address,
    input  logic [31:0] instrucao,
    input  logic        redirect,
    input  logic [9:0]  redirect_addr,
    output logic [31:0] instr_out,
    output logic [9:0]  pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [9:0] PC_LIMIT_W = 10'(PC_LIMIT);
    localparam logic [9:0] BASE_P0_W  = 10'(BASE_P0);
    localparam logic [9:0] BASE_P1_W  = 10'(BASE_P1);
    localparam logic [9:0] BASE_P2_W  = 10'(BASE_P2);

    state_t      state_q, state_d;
    logic [9:0]  pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [9:0]  pc_out_q, pc_out_d;
    logic        valid_q, valid_d;

    logic [9:0]  base_addr;
    logic [9:0]  seq_pc;
    logic        capture;

    // Start address of the selected program; prog_sel=3 falls back to P0.
    always_comb begin
        case (prog_sel)
            2'd1:    base_addr = BASE_P1_W;
            2'd2:    base_addr = BASE_P2_W;
            default: base_addr = BASE_P0_W;
        endcase
    end

    // PC that follows a capture of the current word.
`ifdef FETCH_JUMP_PREDECODE_EN
    localparam logic [5:0] JUMP_OPCODE = 6'b010000;
    always_comb begin
        if (instrucao[31:26] == JUMP_OPCODE) begin
            seq_pc = instrucao[9:0];
        end else begin
            seq_pc = pc_q + 10'd1;
        end
    end
`else
    assign seq_pc = pc_q + 10'd1;
`endif

    // An empty output slot, or one being drained this cycle, is refilled.
    // Refilling on every handshake keeps throughput at one word per cycle.
    assign capture = (state_q == ST_FETCH) && (!valid_q || instr_ready);

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // the branches below leaves it unassigned (no latch is inferred).
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;

        if (start) begin
            // A restart discards any held word.
            pc_d    = base_addr;
            valid_d = 1'b0;
            state_d = ST_FETCH;
        end else if (redirect && (state_q != ST_IDLE)) begin
            // A redirect flushes the held word even when decode is taking it
            // this cycle, because that word lies on the wrong path.
            pc_d    = redirect_addr;
            valid_d = 1'b0;
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (capture) begin
                        instr_d  = instrucao;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = seq_pc;
                        if (pc_q == PC_LIMIT_W) begin
                            state_d = ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    // Only the last word drains here. PC stays where it is.
                    if (valid_q && instr_ready) begin
                        valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values that were present before the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= 10'd0;
            instr_q  <= 32'd0;
            pc_out_q <= 10'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    assign address     = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Bench for instruction_fetch. It uses a behavioural memory and a reference
// model of the program walk. Each start or redirect replaces the expected
// stream of delivered (pc, word) pairs. The model computes that stream from
// program order: addresses count up one at a time, jumps are followed when
// the predecode option is built in, and the walk ends at the limit address.
// A monitor pops one entry for every word that decode accepts.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam int LIMIT = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  prog_sel;
    logic [9:0]  address;
    logic [31:0] instrucao;
    logic        redirect;
    logic [9:0]  redirect_addr;
    logic [31:0] instr_out;
    logic [9:0]  pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;

    logic [31:0] ram [1024];
    assign instrucao = ram[address];

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] word;
    } exp_t;

    exp_t exp_q[$];

    int checks    = 0;
    int passed    = 0;
    int acc_count = 0;
    logic [9:0] last_acc_pc = 10'd0;

    instruction_fetch #(.PC_LIMIT(LIMIT)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .prog_sel      (prog_sel),
        .address       (address),
        .instrucao     (instrucao),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .halted        (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit is_jump_word(input logic [31:0] w);
`ifdef FETCH_JUMP_PREDECODE_EN
        return (w[31:26] == 6'b010000);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [9:0] base_of(input logic [1:0] sel);
        case (sel)
            2'd1:    return 10'd25;
            2'd2:    return 10'd35;
            default: return 10'd1;
        endcase
    endfunction

    // Expected delivery order from a given start point. The walk stops at the
    // limit. The length bound keeps jump loops finite.
    task automatic push_walk(input logic [9:0] from);
        logic [9:0] a;
        a = from;
        exp_q.delete();
        for (int n = 0; n < 1100; n++) begin
            exp_q.push_back('{a, ram[a]});
            if (a == 10'(LIMIT)) break;
            a = is_jump_word(ram[a]) ? ram[a][9:0] : a + 10'd1;
        end
    endtask

    // Inputs change 1 time unit after the rising edge, and outputs are read
    // at the same point.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_start(input logic [1:0] sel);
        start    = 1'b1;
        prog_sel = sel;
        push_walk(base_of(sel));
        step();
        start = 1'b0;
    endtask

    task automatic do_redirect(input logic [9:0] a);
        redirect      = 1'b1;
        redirect_addr = a;
        push_walk(a);
        step();
        redirect = 1'b0;
    endtask

    task automatic wait_pc(input logic [9:0] target, input string name);
        for (int i = 0; i < 300; i++) begin
            if (instr_valid && pc_out == target) return;
            step();
        end
        checks++;
        $display("FAIL %s: timeout waiting for pc_out=%0d, last pc_out=%0d", name, target, pc_out);
    endtask

    // Scoreboard monitor. It samples mid-cycle the handshake that the next
    // edge completes. A start or redirect in the same cycle flushes the word
    // instead of delivering it.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && instr_valid && instr_ready && !start && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL accept_unexpected: pc_out=%0d delivered, none expected", pc_out);
            end else begin
                e = exp_q.pop_front();
                check("acc_pc", 32'(pc_out), 32'(e.pc));
                check("acc_word", instr_out, e.word);
            end
            last_acc_pc = pc_out;
            acc_count++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [9:0]  addr_hold;
        logic [31:0] word_hold;
        bit          seen;

        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            if (w[31:26] == 6'b010000) w[31:26] = 6'b000000;
            ram[i] = w;
        end
        ram[23] = {6'b010000, 16'h0000, 10'd12};

        reset         = 1'b1;
        start         = 1'b0;
        prog_sel      = 2'd0;
        redirect      = 1'b0;
        redirect_addr = 10'd0;
        instr_ready   = 1'b1;
        #1;
        check("rst_address", 32'(address), 32'd0);
        check("rst_instr_out", instr_out, 32'd0);
        check("rst_pc_out", 32'(pc_out), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        step(2);
        reset = 1'b0;
        step();

        // Program 1: first word after 2 edges, then one word per cycle.
        do_start(2'd1);
        check("p1_addr0", 32'(address), 32'd25);
        check("p1_valid0", 32'(instr_valid), 32'd0);
        step();
        check("p1_valid1", 32'(instr_valid), 32'd1);
        check("p1_pc_out1", 32'(pc_out), 32'd25);
        check("p1_word1", instr_out, ram[25]);
        check("p1_addr1", 32'(address), 32'd26);
        step();
        check("p1_pc_out2", 32'(pc_out), 32'd26);
        check("p1_addr2", 32'(address), 32'd27);

        // Stall for 3 cycles while pc_out=3 is held.
        do_start(2'd0);
        wait_pc(10'd3, "stall_wait");
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc_out", 32'(pc_out), 32'd3);
            check("stall_word", instr_out, ram[3]);
            check("stall_addr", 32'(address), 32'd4);
            check("stall_valid", 32'(instr_valid), 32'd1);
        end
        instr_ready = 1'b1;
        step();
        check("stall_resume", 32'(pc_out), 32'd4);

        // Redirect to 61 while pc_out=10 is valid and being accepted.
        wait_pc(10'd10, "redir_wait");
        do_redirect(10'd61);
        check("redir_bubble", 32'(instr_valid), 32'd0);
        check("redir_addr", 32'(address), 32'd61);
        step();
        check("redir_valid", 32'(instr_valid), 32'd1);
        check("redir_pc_out", 32'(pc_out), 32'd61);

        // Jump word at 23 targets 12.
        do_start(2'd0);
        wait_pc(10'd23, "jump_wait");
        step();
`ifdef FETCH_JUMP_PREDECODE_EN
        check("jump_next", 32'(pc_out), 32'd12);
`else
        check("jump_next", 32'(pc_out), 32'd24);
`endif

        // Halt at LIMIT with random back-pressure, then restart.
        do_start(2'd2);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            step();
            if (halted) seen = 1'b1;
        end
        check("halt_seen", 32'(seen), 32'd1);
        check("halt_pc_out", 32'(pc_out), 32'(LIMIT));
        check("halt_valid_held", 32'(instr_valid), 32'd1);
        addr_hold = address;
        instr_ready = 1'b0;
        step();
        check("halt_hold_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        step();
        check("halt_valid_drop", 32'(instr_valid), 32'd0);
        check("halt_still", 32'(halted), 32'd1);
        check("halt_last_acc", 32'(last_acc_pc), 32'(LIMIT));
        check("halt_queue_empty", 32'(exp_q.size()), 32'd0);
        step(2);
        check("halt_pc_frozen", 32'(address), 32'(addr_hold));
        do_start(2'd2);
        check("restart_addr", 32'(address), 32'd35);
        check("restart_halted", 32'(halted), 32'd0);
        check("restart_valid", 32'(instr_valid), 32'd0);

        // Asynchronous reset mid-fetch at PC=14.
        do_start(2'd0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (address == 10'd14) seen = 1'b1;
            else step();
        end
        check("rst14_reached", 32'(seen), 32'd1);
        word_hold = instr_out;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("rst14_address", 32'(address), 32'd0);
        check("rst14_pc_out", 32'(pc_out), 32'd0);
        check("rst14_instr_out", instr_out, 32'd0);
        check("rst14_valid", 32'(instr_valid), 32'd0);
        check("rst14_halted", 32'(halted), 32'd0);
        step();
        reset = 1'b0;
        // IDLE: no fetch, and redirect is ignored.
        redirect      = 1'b1;
        redirect_addr = 10'd5;
        step();
        redirect = 1'b0;
        step();
        check("idle_addr", 32'(address), 32'd0);
        check("idle_valid", 32'(instr_valid), 32'd0);

        // Random traffic: back-pressure, redirects, restarts.
        do_start(2'($urandom_range(0, 3)));
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            instr_ready = ($urandom_range(0, 3) != 0);
            if (r < 2) begin
                do_start(2'($urandom_range(0, 3)));
            end else if (r < 6) begin
                do_redirect(10'($urandom_range(0, LIMIT)));
            end else begin
                step();
            end
        end
        check("random_accepts", 32'(acc_count > 300), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
